// File: rtl/ata_pio_dualtiming_ctrl.sv
// ATA PIO engine: compatible command-port timing plus per-device fast data-port timing,
// IORDY wait with timeout, PIOreq/PIOack host handshake, registered cable pins.
module ata_pio_dualtiming_ctrl #(
    parameter int TWIDTH   = 8,
    parameter int IORDY_TO = 256
) (
    input  logic              clk,
    input  logic              rst,
    output logic              irq,
    input  logic              IDEctrl_rst,
    input  logic              IDEctrl_IDEen,
    input  logic              IDEctrl_FATR0,
    input  logic              IDEctrl_FATR1,
    input  logic [TWIDTH-1:0] PIO_cmdport_T1,
    input  logic [TWIDTH-1:0] PIO_cmdport_T2,
    input  logic [TWIDTH-1:0] PIO_cmdport_T4,
    input  logic [TWIDTH-1:0] PIO_cmdport_Teoc,
    input  logic              PIO_cmdport_IORDYen,
    input  logic [TWIDTH-1:0] PIO_dport0_T1,
    input  logic [TWIDTH-1:0] PIO_dport0_T2,
    input  logic [TWIDTH-1:0] PIO_dport0_T4,
    input  logic [TWIDTH-1:0] PIO_dport0_Teoc,
    input  logic              PIO_dport0_IORDYen,
    input  logic [TWIDTH-1:0] PIO_dport1_T1,
    input  logic [TWIDTH-1:0] PIO_dport1_T2,
    input  logic [TWIDTH-1:0] PIO_dport1_T4,
    input  logic [TWIDTH-1:0] PIO_dport1_Teoc,
    input  logic              PIO_dport1_IORDYen,
    input  logic              PIOreq,
    output logic              PIOack,
    output logic              PIOerr,
    input  logic [3:0]        PIOa,
    input  logic [15:0]       PIOd,
    output logic [15:0]       PIOq,
    input  logic              PIOwe,
    output logic              dev_sel,
    output logic              RESETn,
    output logic [15:0]       DDo,
    output logic              DDoe,
    output logic [2:0]        DA,
    output logic              CS0n,
    output logic              CS1n,
    output logic              DIORn,
    output logic              DIOWn,
    input  logic [15:0]       DDi,
    input  logic              IORDY,
    input  logic              INTRQ
);
    localparam int WW = (IORDY_TO > 1) ? $clog2(IORDY_TO) : 1;

    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_WAIT, S_T4, S_TEOC} state_t;

    state_t            state_q, state_d;
    logic [TWIDTH-1:0] cnt_q, cnt_d, t2_q, t2_d, t4_q, t4_d, teoc_q, teoc_d;
    logic [WW-1:0]     wcnt_q, wcnt_d;
    logic              iordyen_q, iordyen_d, we_q, we_d, reg6_q, reg6_d, dbit_q, dbit_d;
    logic              resetn_q, resetn_d, ddoe_q, ddoe_d, cs0n_q, cs0n_d, cs1n_q, cs1n_d;
    logic              diorn_q, diorn_d, diown_q, diown_d, ack_q, ack_d, err_q, err_d;
    logic              dev_q, dev_d;
    logic [15:0]       ddo_q, ddo_d, pioq_q, pioq_d;
    logic [2:0]        da_q, da_d;
    logic              iordy_s1_q, siordy_q, intrq_s1_q, irq_q;
    logic              use_fast, sel_en, done, done_err;
    logic [TWIDTH-1:0] sel_t1, sel_t2, sel_t4, sel_teoc;

    // Fast timing only applies to the data port of the currently selected device.
    always_comb begin
        use_fast = (PIOa == 4'h0) && (dev_q ? IDEctrl_FATR1 : IDEctrl_FATR0);
        sel_t1   = PIO_cmdport_T1;
        sel_t2   = PIO_cmdport_T2;
        sel_t4   = PIO_cmdport_T4;
        sel_teoc = PIO_cmdport_Teoc;
        sel_en   = PIO_cmdport_IORDYen;
        if (use_fast && dev_q) begin
            sel_t1 = PIO_dport1_T1;  sel_t2 = PIO_dport1_T2;
            sel_t4 = PIO_dport1_T4;  sel_teoc = PIO_dport1_Teoc;
            sel_en = PIO_dport1_IORDYen;
        end else if (use_fast) begin
            sel_t1 = PIO_dport0_T1;  sel_t2 = PIO_dport0_T2;
            sel_t4 = PIO_dport0_T4;  sel_teoc = PIO_dport0_Teoc;
            sel_en = PIO_dport0_IORDYen;
        end
    end

    always_comb begin
        state_d = state_q;   cnt_d = cnt_q;     wcnt_d = wcnt_q;
        t2_d = t2_q;         t4_d = t4_q;       teoc_d = teoc_q;
        iordyen_d = iordyen_q; we_d = we_q;     reg6_d = reg6_q;  dbit_d = dbit_q;
        resetn_d = !IDEctrl_rst;
        ddo_d = ddo_q;       ddoe_d = ddoe_q;   da_d = da_q;
        cs0n_d = cs0n_q;     cs1n_d = cs1n_q;   diorn_d = diorn_q; diown_d = diown_q;
        ack_d = 1'b0;        err_d = 1'b0;      pioq_d = pioq_q;  dev_d = dev_q;
        done = 1'b0;         done_err = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (PIOreq && !ack_q) begin
                    if (!IDEctrl_IDEen) begin
                        ack_d = 1'b1;
                    end else begin
                        state_d = S_T1;      cnt_d = sel_t1;
                        t2_d = sel_t2;       t4_d = sel_t4;
                        teoc_d = sel_teoc;   iordyen_d = sel_en;
                        we_d = PIOwe;        reg6_d = (PIOa == 4'h6);  dbit_d = PIOd[4];
                        da_d = PIOa[2:0];    cs0n_d = PIOa[3];  cs1n_d = !PIOa[3];
                        if (PIOwe) begin
                            ddo_d  = PIOd;
                            ddoe_d = 1'b1;
                        end
                    end
                end
            end
            S_T1: begin
                if (cnt_q == '0) begin
                    state_d = S_T2;
                    cnt_d   = t2_q;
                    if (we_q) diown_d = 1'b0;
                    else      diorn_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_T2: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (iordyen_q && !siordy_q) begin
                    state_d = S_WAIT;
                    wcnt_d  = '0;
                end else begin
                    done = 1'b1;
                end
            end
            S_WAIT: begin
                if (siordy_q) begin
                    done = 1'b1;
                end else if ((IORDY_TO > 0) && (wcnt_q == WW'(IORDY_TO - 1))) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_T4: begin
                if (cnt_q == '0) begin
                    state_d = S_TEOC;  cnt_d = teoc_q;
                    cs0n_d = 1'b1;     cs1n_d = 1'b1;  ddoe_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_TEOC: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d = cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        // Strobe negation edge: completion, read capture and DEV tracking all happen here.
        if (done) begin
            state_d = S_T4;    cnt_d = t4_q;
            diorn_d = 1'b1;    diown_d = 1'b1;
            ack_d = 1'b1;      err_d = done_err;
            if (!we_q) pioq_d = DDi;
            if (we_q && reg6_q) dev_d = dbit_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;  cnt_q <= '0;  wcnt_q <= '0;
            t2_q <= '0;  t4_q <= '0;  teoc_q <= '0;
            iordyen_q <= 1'b0;  we_q <= 1'b0;  reg6_q <= 1'b0;  dbit_q <= 1'b0;
            resetn_q <= 1'b0;  ddo_q <= '0;  ddoe_q <= 1'b0;  da_q <= '0;
            cs0n_q <= 1'b1;  cs1n_q <= 1'b1;  diorn_q <= 1'b1;  diown_q <= 1'b1;
            ack_q <= 1'b0;  err_q <= 1'b0;  pioq_q <= '0;  dev_q <= 1'b0;
            iordy_s1_q <= 1'b0;  siordy_q <= 1'b0;  intrq_s1_q <= 1'b0;  irq_q <= 1'b0;
        end else begin
            state_q <= state_d;  cnt_q <= cnt_d;  wcnt_q <= wcnt_d;
            t2_q <= t2_d;  t4_q <= t4_d;  teoc_q <= teoc_d;
            iordyen_q <= iordyen_d;  we_q <= we_d;  reg6_q <= reg6_d;  dbit_q <= dbit_d;
            resetn_q <= resetn_d;  ddo_q <= ddo_d;  ddoe_q <= ddoe_d;  da_q <= da_d;
            cs0n_q <= cs0n_d;  cs1n_q <= cs1n_d;  diorn_q <= diorn_d;  diown_q <= diown_d;
            ack_q <= ack_d;  err_q <= err_d;  pioq_q <= pioq_d;  dev_q <= dev_d;
            iordy_s1_q <= IORDY;  siordy_q <= iordy_s1_q;
            intrq_s1_q <= INTRQ;  irq_q <= intrq_s1_q;
        end
    end

    assign irq     = irq_q;
    assign PIOack  = ack_q;
    assign PIOerr  = err_q;
    assign PIOq    = pioq_q;
    assign dev_sel = dev_q;
    assign RESETn  = resetn_q;
    assign DDo     = ddo_q;
    assign DDoe    = ddoe_q;
    assign DA      = da_q;
    assign CS0n    = cs0n_q;
    assign CS1n    = cs1n_q;
    assign DIORn   = diorn_q;
    assign DIOWn   = diown_q;
endmodule

// File: tb/tb_ata_pio_dualtiming_ctrl.sv
// Scenario bench for ata_pio_dualtiming_ctrl; expected completions are queued at issue
// and retired against PIOack/PIOerr/PIOq, bus-cycle shapes are checked per scenario.
module tb_ata_pio_dualtiming_ctrl;
    logic clk = 1'b0;
    logic rst, irq, IDEctrl_rst, IDEctrl_IDEen, IDEctrl_FATR0, IDEctrl_FATR1;
    logic [7:0] c_t1, c_t2, c_t4, c_teoc, d0_t1, d0_t2, d0_t4, d0_teoc, d1_t1, d1_t2, d1_t4, d1_teoc;
    logic c_en, d0_en, d1_en;
    logic PIOreq, PIOack, PIOerr, PIOwe, dev_sel, RESETn, DDoe, CS0n, CS1n, DIORn, DIOWn;
    logic [3:0] PIOa;
    logic [15:0] PIOd, PIOq, DDo, DDi;
    logic [2:0] DA;
    logic IORDY, INTRQ;

    typedef struct packed { logic err; logic rd; logic [15:0] q; } exp_t;
    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    logic r_cs0n [0:40];
    logic r_cs1n [0:40];
    logic r_dior [0:40];
    logic r_diow [0:40];
    logic r_ddoe [0:40];
    logic r_ack  [0:40];
    logic [15:0] r_ddo [0:40];
    logic [2:0]  r_da  [0:40];

    always #5 clk = ~clk;

    ata_pio_dualtiming_ctrl #(.TWIDTH(8), .IORDY_TO(16)) dut (
        .clk(clk), .rst(rst), .irq(irq), .IDEctrl_rst(IDEctrl_rst), .IDEctrl_IDEen(IDEctrl_IDEen),
        .IDEctrl_FATR0(IDEctrl_FATR0), .IDEctrl_FATR1(IDEctrl_FATR1),
        .PIO_cmdport_T1(c_t1), .PIO_cmdport_T2(c_t2), .PIO_cmdport_T4(c_t4),
        .PIO_cmdport_Teoc(c_teoc), .PIO_cmdport_IORDYen(c_en),
        .PIO_dport0_T1(d0_t1), .PIO_dport0_T2(d0_t2), .PIO_dport0_T4(d0_t4),
        .PIO_dport0_Teoc(d0_teoc), .PIO_dport0_IORDYen(d0_en),
        .PIO_dport1_T1(d1_t1), .PIO_dport1_T2(d1_t2), .PIO_dport1_T4(d1_t4),
        .PIO_dport1_Teoc(d1_teoc), .PIO_dport1_IORDYen(d1_en),
        .PIOreq(PIOreq), .PIOack(PIOack), .PIOerr(PIOerr), .PIOa(PIOa), .PIOd(PIOd), .PIOq(PIOq),
        .PIOwe(PIOwe), .dev_sel(dev_sel), .RESETn(RESETn), .DDo(DDo), .DDoe(DDoe), .DA(DA),
        .CS0n(CS0n), .CS1n(CS1n), .DIORn(DIORn), .DIOWn(DIOWn), .DDi(DDi), .IORDY(IORDY), .INTRQ(INTRQ)
    );

    // One clock; retire a scoreboard entry on PIOack and release the request.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (PIOack) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_ack PIOerr=%b PIOq=%h required=no_ack", PIOerr, PIOq);
            end else begin
                e = sb.pop_front();
                if (PIOerr !== e.err || (e.rd && PIOq !== e.q)) begin
                    failures++;
                    $display("FAIL sb_completion err=%b q=%h required err=%b q=%h(rd=%b)",
                             PIOerr, PIOq, e.err, e.q, e.rd);
                end
            end
            PIOreq = 1'b0;
        end
    endtask

    task automatic issue(input logic [3:0] a, input logic [15:0] d, input logic we,
                         input logic [15:0] ddi, input logic experr);
        PIOa = a; PIOd = d; PIOwe = we; DDi = ddi; PIOreq = 1'b1;
        sb.push_back('{err: experr, rd: !we, q: ddi});
    endtask

    task automatic record(input int n, input int rereq_k);
        for (int k = 1; k <= n; k++) begin
            step();
            r_cs0n[k] = CS0n; r_cs1n[k] = CS1n; r_dior[k] = DIORn; r_diow[k] = DIOWn;
            r_ddoe[k] = DDoe; r_ack[k] = PIOack; r_ddo[k] = DDo; r_da[k] = DA;
            if (k == rereq_k) issue(4'h7, 16'h0000, 1'b0, 16'h1234, 1'b0);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 80) begin step(); n++; end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
        repeat (10) step();
    endtask

    task automatic set_cmd(input int t1, input int t2, input int t4, input int teoc, input logic en);
        c_t1 = 8'(t1); c_t2 = 8'(t2); c_t4 = 8'(t4); c_teoc = 8'(teoc); c_en = en;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks += 4;
        if ({RESETn, DIORn, DIOWn, CS0n, CS1n, DDoe, PIOack, PIOerr, dev_sel, irq} !== 10'b0111100000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b required=0111100000",
                     {RESETn, DIORn, DIOWn, CS0n, CS1n, DDoe, PIOack, PIOerr, dev_sel, irq});
        end
        if (DA !== 3'd0) begin failures++; $display("FAIL reset_DA got=%h required=0", DA); end
        if (DDo !== 16'h0) begin failures++; $display("FAIL reset_DDo got=%h required=0", DDo); end
        if (PIOq !== 16'h0) begin failures++; $display("FAIL reset_PIOq got=%h required=0", PIOq); end
        rst = 1'b0;
        step();
        checks++;
        if (RESETn !== 1'b1) begin failures++; $display("FAIL resetn_release got=%b required=1", RESETn); end
        IDEctrl_rst = 1'b1;
        step();
        checks++;
        if (RESETn !== 1'b0) begin failures++; $display("FAIL resetn_ctrl got=%b required=0", RESETn); end
        IDEctrl_rst = 1'b0; INTRQ = 1'b1;
        step();
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_sync1 got=%b required=0", irq); end
        step();
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL irq_sync2 got=%b required=1", irq); end
        INTRQ = 1'b0;
        step(); step();
    endtask

    task automatic test_cmd_write();
        int nk = 0;
        set_cmd(2, 4, 1, 3, 1'b0);
        issue(4'h7, 16'h00EC, 1'b1, 16'h0000, 1'b0);
        record(30, 10);
        for (int k = 1; k <= 14; k++) begin
            checks += 4;
            if (r_cs0n[k] !== (k > 10) || r_cs1n[k] !== 1'b1) begin
                failures++; $display("FAIL t1_cs k=%0d cs0n=%b cs1n=%b required cs0n=%b cs1n=1", k, r_cs0n[k], r_cs1n[k], k > 10);
            end
            if (r_diow[k] !== !(k >= 4 && k <= 8) || r_dior[k] !== 1'b1) begin
                failures++; $display("FAIL t1_strobe k=%0d diow=%b dior=%b required diow=%b dior=1", k, r_diow[k], r_dior[k], !(k >= 4 && k <= 8));
            end
            if (r_ddoe[k] !== (k <= 10)) begin
                failures++; $display("FAIL t1_ddoe k=%0d got=%b required=%b", k, r_ddoe[k], k <= 10);
            end
            if (r_ack[k] !== (k == 9)) begin
                failures++; $display("FAIL t1_ack k=%0d got=%b required=%b", k, r_ack[k], k == 9);
            end
            if (k <= 10) begin
                checks++;
                if (r_da[k] !== 3'd7 || r_ddo[k] !== 16'h00EC) begin
                    failures++; $display("FAIL t1_addr_data k=%0d DA=%h DDo=%h required DA=7 DDo=00ec", k, r_da[k], r_ddo[k]);
                end
            end
        end
        for (int k = 11; k <= 30; k++) if (nk == 0 && r_cs0n[k] == 1'b0) nk = k;
        checks++;
        if (nk < 15) begin failures++; $display("FAIL t1_next_accept cs_low_cycle=%0d required>=15", nk); end
        drain();
    endtask

    task automatic test_dev_select();
        int lows, first;
        set_cmd(1, 3, 0, 0, 1'b0);
        d1_t1 = 8'd0; d1_t2 = 8'd1; d1_t4 = 8'd0; d1_teoc = 8'd0; d1_en = 1'b0;
        d0_t1 = 8'd0; d0_t2 = 8'd5; d0_t4 = 8'd0; d0_teoc = 8'd0; d0_en = 1'b0;
        IDEctrl_FATR0 = 1'b0; IDEctrl_FATR1 = 1'b1;
        issue(4'h6, 16'h0010, 1'b1, 16'h0000, 1'b0);
        drain();
        checks++;
        if (dev_sel !== 1'b1) begin failures++; $display("FAIL dev_sel_set got=%b required=1", dev_sel); end
        for (int pass = 0; pass < 2; pass++) begin
            IDEctrl_FATR1 = (pass == 0); IDEctrl_FATR0 = (pass == 1);
            issue(4'h0, 16'h0000, 1'b0, (pass == 0) ? 16'hA55A : 16'hC33C, 1'b0);
            record(14, 0);
            lows = 0; first = 0;
            for (int k = 1; k <= 14; k++) if (r_dior[k] == 1'b0) begin lows++; if (first == 0) first = k; end
            checks++;
            if (lows != ((pass == 0) ? 2 : 4) || first != ((pass == 0) ? 2 : 3)) begin
                failures++; $display("FAIL dport_timing pass=%0d low_cycles=%0d first=%0d required %0d/%0d",
                                     pass, lows, first, (pass == 0) ? 2 : 4, (pass == 0) ? 2 : 3);
            end
            drain();
        end
        IDEctrl_FATR0 = 1'b0; IDEctrl_FATR1 = 1'b0;
    endtask

    task automatic test_iordy_wait();
        set_cmd(0, 2, 0, 0, 1'b1);
        issue(4'h1, 16'h0000, 1'b0, 16'h5A5A, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            step();
            r_dior[k] = DIORn; r_ack[k] = PIOack;
            if (k == 1)  IORDY = 1'b0;
            if (k == 11) IORDY = 1'b1;
        end
        for (int k = 1; k <= 16; k++) begin
            checks++;
            if (r_dior[k] !== !(k >= 2 && k <= 13) || r_ack[k] !== (k == 14)) begin
                failures++; $display("FAIL iordy_wait k=%0d dior=%b ack=%b required dior=%b ack=%b",
                                     k, r_dior[k], r_ack[k], !(k >= 2 && k <= 13), k == 14);
            end
        end
        drain();
    endtask

    task automatic test_timeout();
        set_cmd(0, 2, 0, 0, 1'b1);
        issue(4'h6, 16'h0000, 1'b1, 16'h0000, 1'b1);
        for (int k = 1; k <= 24; k++) begin
            step();
            r_diow[k] = DIOWn; r_ack[k] = PIOack; r_cs0n[k] = CS0n;
            if (k == 1) IORDY = 1'b0;
        end
        for (int k = 1; k <= 24; k++) begin
            checks++;
            if (r_diow[k] !== !(k >= 2 && k <= 20) || r_ack[k] !== (k == 21) || r_cs0n[k] !== (k >= 22)) begin
                failures++; $display("FAIL timeout k=%0d diow=%b ack=%b cs0n=%b required %b/%b/%b",
                                     k, r_diow[k], r_ack[k], r_cs0n[k], !(k >= 2 && k <= 20), k == 21, k >= 22);
            end
        end
        IORDY = 1'b1;
        drain();
        checks++;
        if (dev_sel !== 1'b0) begin failures++; $display("FAIL timeout_dev_sel got=%b required=0", dev_sel); end
    endtask

    task automatic test_disabled();
        IDEctrl_IDEen = 1'b0;
        issue(4'h7, 16'h0000, 1'b1, 16'h0000, 1'b0);
        record(5, 0);
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if (r_ack[k] !== (k == 1) || {r_cs0n[k], r_cs1n[k], r_dior[k], r_diow[k]} !== 4'b1111) begin
                failures++; $display("FAIL disabled k=%0d ack=%b bus=%b required ack=%b bus=1111",
                                     k, r_ack[k], {r_cs0n[k], r_cs1n[k], r_dior[k], r_diow[k]}, k == 1);
            end
        end
        IDEctrl_IDEen = 1'b1;
        drain();
    endtask

    task automatic test_reset_abort();
        exp_t dropped;
        set_cmd(0, 4, 0, 0, 1'b0);
        issue(4'h6, 16'h0010, 1'b1, 16'h0000, 1'b0);
        drain();
        checks++;
        if (dev_sel !== 1'b1) begin failures++; $display("FAIL abort_dev_pre got=%b required=1", dev_sel); end
        issue(4'h0, 16'h0000, 1'b0, 16'h7777, 1'b0);
        step(); step(); step();
        checks++;
        if (DIORn !== 1'b0) begin failures++; $display("FAIL abort_in_t2 DIORn=%b required=0", DIORn); end
        rst = 1'b1;
        dropped = sb.pop_back();
        step();
        checks++;
        if ({DIORn, CS0n, CS1n, DDoe, RESETn, dev_sel, PIOack} !== 7'b1110000) begin
            failures++; $display("FAIL abort_state got=%b required=1110000 (dropped q=%h)",
                                 {DIORn, CS0n, CS1n, DDoe, RESETn, dev_sel, PIOack}, dropped.q);
        end
        rst = 1'b0; PIOreq = 1'b0;
        repeat (6) step();
        checks++;
        if (RESETn !== 1'b1) begin failures++; $display("FAIL abort_resetn got=%b required=1", RESETn); end
        issue(4'h7, 16'h0042, 1'b1, 16'h0000, 1'b0);
        record(3, 0);
        checks++;
        if (r_cs0n[1] !== 1'b0 || r_diow[2] !== 1'b0 || r_ddo[1] !== 16'h0042) begin
            failures++; $display("FAIL abort_recover cs0n=%b diow=%b ddo=%h required 0/0/0042", r_cs0n[1], r_diow[2], r_ddo[1]);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int nk = 0;
        set_cmd(0, 0, 0, 0, 1'b0);
        issue(4'h7, 16'h1111, 1'b1, 16'h0000, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            step();
            r_cs0n[k] = CS0n; r_diow[k] = DIOWn; r_ack[k] = PIOack;
            if (k == 1) c_t2 = 8'd5;
            if (k == 4) issue(4'h7, 16'h2222, 1'b1, 16'h0000, 1'b0);
        end
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (r_cs0n[k] !== (k == 4) || r_diow[k] !== (k != 2) || r_ack[k] !== (k == 3)) begin
                failures++; $display("FAIL b2b_min k=%0d cs0n=%b diow=%b ack=%b required %b/%b/%b",
                                     k, r_cs0n[k], r_diow[k], r_ack[k], k == 4, k != 2, k == 3);
            end
        end
        for (int k = 5; k <= 12; k++) if (nk == 0 && r_cs0n[k] == 1'b0) nk = k;
        checks++;
        if (nk < 5) begin failures++; $display("FAIL b2b_next_accept cs_low_cycle=%0d required>=5", nk); end
        drain();
        c_t2 = 8'd0;
    endtask

    initial begin
        rst = 1'b1; IDEctrl_rst = 1'b0; IDEctrl_IDEen = 1'b1; IDEctrl_FATR0 = 1'b0; IDEctrl_FATR1 = 1'b0;
        set_cmd(0, 0, 0, 0, 1'b0);
        d0_t1 = 8'd0; d0_t2 = 8'd0; d0_t4 = 8'd0; d0_teoc = 8'd0; d0_en = 1'b0;
        d1_t1 = 8'd0; d1_t2 = 8'd0; d1_t4 = 8'd0; d1_teoc = 8'd0; d1_en = 1'b0;
        PIOreq = 1'b0; PIOa = 4'h0; PIOd = 16'h0; PIOwe = 1'b0; DDi = 16'h0; IORDY = 1'b1; INTRQ = 1'b0;
        test_reset();
        test_cmd_write();
        test_dev_select();
        test_iordy_wait();
        test_timeout();
        test_disabled();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
